meter_readout_ctrl: RTL and testbench
=====================================

// Module: meter_readout_ctrl
// PURPOSE
//  Snapshot scheduler and host readout controller for the stereo audio meter block.
//  Counts valid samples and, every SNAP_PERIOD samples, freezes meter peak/rms plus per-channel clip counts.
//  Serves the frozen snapshot to a host over a request/ack read port and flags overrun when the host is late.
//  Sits between the meter outputs and the control-register interface; owns all meter sampling timing.
// PARAMETERS
//  SNAP_PERIOD  4800       valid samples per snapshot (100 ms @ 48 kHz); legal range 2..65535
//  CLIP_THRESH  24'h7FFF00 |sample| >= this counts as a clip (magnitude compare, unsigned)
// PORTS
//  clk         in   1   system clock; single clock domain
//  rst_n       in   1   synchronous reset, active low
//  in_valid    in   1   sample strobe, same stream that feeds the meters
//  in_l/in_r   in   24  signed two's-complement audio samples
//  peak_l/_r   in   24  meter peak outputs
//  rms_l/_r    in   24  meter rms outputs
//  rd_req      in   1   host read request (sampled every cycle)
//  rd_sel      in   3   word select: 0 peak_l,1 peak_r,2 rms_l,3 rms_r,4 status; 5-7 read as 0
//  snap_clr    in   1   host done with snapshot (pulse)
//  rd_ack      out  1   one-cycle pulse, rd_data valid this cycle
//  rd_data     out  24  read data
//  snap_ready  out  1   high while an unread snapshot is held (level, usable as irq)
//  overrun     out  1   sticky: a period ended while snapshot still unread; cleared by snap_clr
// BEHAVIOUR
//  Reset: clk edge with rst_n=0 clears every register; all outputs 0, FSM=S_RUN, counter=0, clip counts 0.
//  Sample counter: increments on in_valid; value SNAP_PERIOD-1 with in_valid => wrap to 0, asserts 'wrap' that cycle.
//  Clip counters clip_l/clip_r (8b): +1 on in_valid when |x|>=CLIP_THRESH; saturate at 255.
//   |x| = x[23] ? -x : x as 24b unsigned; 24'h800000 -> 24'h800000 (clips).
//   Sample on the wrap cycle is counted in the closing period.
//  FSM states:
//   S_RUN:   wait; wrap -> S_CAP.
//   S_CAP:   one cycle; copy peak/rms/clip counts (incl. wrap sample) into snapshot regs, zero live clip
//            counters (a clip on this cycle counts into the new period) -> S_READY.
//   S_READY: snap_ready=1. snap_clr -> S_RUN. wrap without snap_clr -> stay, set overrun, snapshot NOT overwritten,
//            live clip counters keep accumulating. wrap with snap_clr same cycle -> S_CAP (fresh capture, no overrun).
//  snap_clr outside S_READY: ignored except it clears overrun.
//  Read port: rd_req at cycle n -> rd_ack=1 and rd_data valid at n+1; rd_ack/rd_data back to 0 at n+2 if no new req.
//   Back-to-back rd_req each cycle -> ack each cycle. Reads legal in any state; return snapshot regs.
//   Status word (sel 4): {snap_clip_l[7:0], snap_clip_r[7:0], 6'b0, overrun, snap_ready}.
//  Reset mid-operation: any state returns to S_RUN with snapshot zeroed; pending ack dropped.
//  Latency: wrap -> snap_ready high 2 cycles later (S_CAP then S_READY).
// CONFIGURATION
//  METER_PEAKMAX_EN defined: block keeps per-channel running max of peak_l/peak_r over the period
//   (updated on in_valid, reset to 0 after S_CAP); snapshot peak = max(running max, peak at capture).
//  Undefined: snapshot peak = peak_l/peak_r as sampled in S_CAP cycle; no extra registers.
//  rms capture and all other behaviour identical in both builds.
// TESTING (bench with SNAP_PERIOD=4)
//  Reset: rst_n=0 for 2 clks -> rd_ack=0, rd_data=0, snap_ready=0, overrun=0; read sel 4 returns 0.
//  4 valid samples, peak_l=24'h123456 held -> snap_ready rises 2 clks after 4th; sel 0 reads 24'h123456, ack 1 clk after req.
//  Samples 24'h7FFFFF,24'h800000,24'h000100,24'h7FFF00 on L -> status clip_l=3, clip_r=0.
//  Do not clr across 4 more samples -> overrun=1, snapshot unchanged; snap_clr -> overrun=0, snap_ready=0.
//  snap_clr on same cycle as wrap in S_READY -> new capture, snap_ready stays/reasserts, overrun=0.
//  300 clipping samples with SNAP_PERIOD=512 -> clip_l saturates at 255; with METER_PEAKMAX_EN, peak_l
//   pulse 24'h400000 mid-period then 24'h001000 -> snapshot peak 24'h400000 (24'h001000 without macro).

Source files
------------

// File: rtl/meter_readout_ctrl_if.sv
// Host-side register port of meter_readout_ctrl: read request/ack, snapshot
// release and status flags.
interface meter_readout_ctrl_if;
    logic        rd_req;
    logic [2:0]  rd_sel;
    logic        snap_clr;
    logic        rd_ack;
    logic [23:0] rd_data;
    logic        snap_ready;
    logic        overrun;

    modport master (
        output rd_req, rd_sel, snap_clr,
        input  rd_ack, rd_data, snap_ready, overrun
    );

    modport slave (
        input  rd_req, rd_sel, snap_clr,
        output rd_ack, rd_data, snap_ready, overrun
    );
endinterface

// File: rtl/meter_readout_ctrl.sv
// Snapshot scheduler and host readout for the stereo audio meter.
// Optional METER_PEAKMAX_EN: snapshot peak is the max seen over the whole period.
module meter_readout_ctrl #(
    parameter int unsigned SNAP_PERIOD = 4800,
    parameter logic [23:0] CLIP_THRESH = 24'h7FFF00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [23:0]          in_l,
    input  logic [23:0]          in_r,
    input  logic [23:0]          peak_l,
    input  logic [23:0]          peak_r,
    input  logic [23:0]          rms_l,
    input  logic [23:0]          rms_r,
    meter_readout_ctrl_if.slave  host
);

    localparam int unsigned CntW = 16;
    localparam logic [CntW-1:0] CntLast = CntW'(SNAP_PERIOD - 1);

    typedef enum logic [1:0] {StRun, StCap, StReady} state_e;

    state_e state_q, state_d;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      clip_l_q, clip_l_d;
    logic [7:0]      clip_r_q, clip_r_d;
    logic            overrun_q, overrun_d;
    logic [23:0]     snap_peak_l_q, snap_peak_r_q;
    logic [23:0]     snap_rms_l_q, snap_rms_r_q;
    logic [7:0]      snap_clip_l_q, snap_clip_r_q;
    logic            rd_ack_q;
    logic [23:0]     rd_data_q;

    logic        wrap;
    logic        snap_load;
    logic        hit_l, hit_r;
    logic [23:0] cap_peak_l, cap_peak_r;
    logic [23:0] rd_mux;
    logic        snap_ready;

    // Two's-complement magnitude; 24'h800000 maps to itself and still clips.
    function automatic logic [23:0] mag(input logic [23:0] x);
        return x[23] ? (~x + 24'd1) : x;
    endfunction

    assign wrap       = in_valid && (cnt_q == CntLast);
    assign hit_l      = mag(in_l) >= CLIP_THRESH;
    assign hit_r      = mag(in_r) >= CLIP_THRESH;
    assign snap_ready = (state_q == StReady);

    always_comb begin
        cnt_d = cnt_q;
        if (in_valid) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    // Capture cycle restarts the live counts; a clip on that cycle opens the new period.
    always_comb begin
        clip_l_d = clip_l_q;
        clip_r_d = clip_r_q;
        if (state_q == StCap) begin
            clip_l_d = {7'd0, in_valid && hit_l};
            clip_r_d = {7'd0, in_valid && hit_r};
        end else begin
            if (in_valid && hit_l && (clip_l_q != 8'hFF)) clip_l_d = clip_l_q + 8'd1;
            if (in_valid && hit_r && (clip_r_q != 8'hFF)) clip_r_d = clip_r_q + 8'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        snap_load = 1'b0;
        unique case (state_q)
            StRun: begin
                if (wrap) state_d = StCap;
            end
            StCap: begin
                snap_load = 1'b1;
                state_d   = StReady;
            end
            StReady: begin
                if (host.snap_clr) state_d = wrap ? StCap : StRun;
            end
            default: state_d = StRun;
        endcase
    end

    // An unread snapshot is kept on a late host; the lost period is flagged instead.
    always_comb begin
        overrun_d = overrun_q;
        if (host.snap_clr) begin
            overrun_d = 1'b0;
        end else if ((state_q == StReady) && wrap) begin
            overrun_d = 1'b1;
        end
    end

`ifdef METER_PEAKMAX_EN
    logic [23:0] pmax_l_q, pmax_l_d;
    logic [23:0] pmax_r_q, pmax_r_d;

    always_comb begin
        pmax_l_d = pmax_l_q;
        pmax_r_d = pmax_r_q;
        if (state_q == StCap) begin
            pmax_l_d = '0;
            pmax_r_d = '0;
        end else if (in_valid) begin
            if (peak_l > pmax_l_q) pmax_l_d = peak_l;
            if (peak_r > pmax_r_q) pmax_r_d = peak_r;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pmax_l_q <= '0;
            pmax_r_q <= '0;
        end else begin
            pmax_l_q <= pmax_l_d;
            pmax_r_q <= pmax_r_d;
        end
    end

    assign cap_peak_l = (peak_l > pmax_l_q) ? peak_l : pmax_l_q;
    assign cap_peak_r = (peak_r > pmax_r_q) ? peak_r : pmax_r_q;
`else
    assign cap_peak_l = peak_l;
    assign cap_peak_r = peak_r;
`endif

    always_comb begin
        rd_mux = '0;
        case (host.rd_sel)
            3'd0:    rd_mux = snap_peak_l_q;
            3'd1:    rd_mux = snap_peak_r_q;
            3'd2:    rd_mux = snap_rms_l_q;
            3'd3:    rd_mux = snap_rms_r_q;
            3'd4:    rd_mux = {snap_clip_l_q, snap_clip_r_q, 6'b0, overrun_q, snap_ready};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StRun;
            cnt_q         <= '0;
            clip_l_q      <= '0;
            clip_r_q      <= '0;
            overrun_q     <= 1'b0;
            snap_peak_l_q <= '0;
            snap_peak_r_q <= '0;
            snap_rms_l_q  <= '0;
            snap_rms_r_q  <= '0;
            snap_clip_l_q <= '0;
            snap_clip_r_q <= '0;
            rd_ack_q      <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clip_l_q  <= clip_l_d;
            clip_r_q  <= clip_r_d;
            overrun_q <= overrun_d;
            if (snap_load) begin
                snap_peak_l_q <= cap_peak_l;
                snap_peak_r_q <= cap_peak_r;
                snap_rms_l_q  <= rms_l;
                snap_rms_r_q  <= rms_r;
                snap_clip_l_q <= clip_l_q;
                snap_clip_r_q <= clip_r_q;
            end
            rd_ack_q  <= host.rd_req;
            rd_data_q <= host.rd_req ? rd_mux : '0;
        end
    end

    assign host.rd_ack     = rd_ack_q;
    assign host.rd_data    = rd_data_q;
    assign host.snap_ready = snap_ready;
    assign host.overrun    = overrun_q;

endmodule

// File: tb/tb_meter_readout_ctrl.sv
// Directed bench for meter_readout_ctrl: a SNAP_PERIOD=4 instance for the main
// flow and a SNAP_PERIOD=512 instance for clip saturation and peak capture.
module tb_meter_readout_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        va, vb;
    logic [23:0] in_l, in_r, peak_l, peak_r, rms_l, rms_r;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef METER_PEAKMAX_EN
    localparam logic [23:0] ExpPeakB = 24'h400000;
`else
    localparam logic [23:0] ExpPeakB = 24'h001000;
`endif

    always #5 clk = ~clk;

    meter_readout_ctrl_if ha ();
    meter_readout_ctrl_if hb ();

    meter_readout_ctrl #(.SNAP_PERIOD(4)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (va),
        .in_l     (in_l),
        .in_r     (in_r),
        .peak_l   (peak_l),
        .peak_r   (peak_r),
        .rms_l    (rms_l),
        .rms_r    (rms_r),
        .host     (ha)
    );

    meter_readout_ctrl #(.SNAP_PERIOD(512)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (vb),
        .in_l     (in_l),
        .in_r     (in_r),
        .peak_l   (peak_l),
        .peak_r   (peak_r),
        .rms_l    (rms_l),
        .rms_r    (rms_r),
        .host     (hb)
    );

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_a(input logic [23:0] l, input logic [23:0] r);
        va   = 1'b1;
        in_l = l;
        in_r = r;
        tick();
        va   = 1'b0;
    endtask

    task automatic read_a(input logic [2:0] sel, input logic [23:0] exp, input string tag);
        ha.rd_req = 1'b1;
        ha.rd_sel = sel;
        tick();
        check({tag, "_ack"}, {23'd0, ha.rd_ack}, 24'd1);
        check(tag, ha.rd_data, exp);
        ha.rd_req = 1'b0;
        tick();
        check({tag, "_ack_drop"}, {23'd0, ha.rd_ack}, 24'd0);
    endtask

    task automatic read_b(input logic [2:0] sel, input logic [23:0] exp, input string tag);
        hb.rd_req = 1'b1;
        hb.rd_sel = sel;
        tick();
        check({tag, "_ack"}, {23'd0, hb.rd_ack}, 24'd1);
        check(tag, hb.rd_data, exp);
        hb.rd_req = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        va = 1'b0; vb = 1'b0;
        in_l = '0; in_r = '0; peak_l = '0; peak_r = '0; rms_l = '0; rms_r = '0;
        ha.rd_req = 1'b0; ha.rd_sel = '0; ha.snap_clr = 1'b0;
        hb.rd_req = 1'b0; hb.rd_sel = '0; hb.snap_clr = 1'b0;

        // Reset
        tick();
        tick();
        check("rst_ack", {23'd0, ha.rd_ack}, 24'd0);
        check("rst_data", ha.rd_data, 24'd0);
        check("rst_ready", {23'd0, ha.snap_ready}, 24'd0);
        check("rst_overrun", {23'd0, ha.overrun}, 24'd0);
        check("rst_ready_b", {23'd0, hb.snap_ready}, 24'd0);
        rst_n = 1'b1;
        read_a(3'd4, 24'h000000, "rst_status");

        // First period: clip magnitudes incl. the 24'h800000 edge case
        peak_l = 24'h123456; peak_r = 24'h000777;
        rms_l  = 24'h0A0B0C; rms_r  = 24'h010203;
        sample_a(24'h7FFFFF, 24'h0);
        sample_a(24'h800000, 24'h0);
        sample_a(24'h000100, 24'h0);
        sample_a(24'h7FFF00, 24'h0);
        check("cap_not_ready", {23'd0, ha.snap_ready}, 24'd0);
        tick();
        check("ready_rise", {23'd0, ha.snap_ready}, 24'd1);
        read_a(3'd0, 24'h123456, "p1_peak_l");
        read_a(3'd1, 24'h000777, "p1_peak_r");
        read_a(3'd2, 24'h0A0B0C, "p1_rms_l");
        read_a(3'd3, 24'h010203, "p1_rms_r");
        read_a(3'd4, 24'h030001, "p1_status");
        read_a(3'd5, 24'h000000, "p1_sel5");

        // Late host: a full period passes without snap_clr
        peak_l = 24'h111111;
        for (int i = 0; i < 4; i++) sample_a(24'h0, 24'h0);
        check("ovr_set", {23'd0, ha.overrun}, 24'd1);
        check("ovr_ready", {23'd0, ha.snap_ready}, 24'd1);
        read_a(3'd0, 24'h123456, "ovr_peak_kept");
        read_a(3'd4, 24'h030003, "ovr_status");
        ha.snap_clr = 1'b1;
        tick();
        ha.snap_clr = 1'b0;
        check("clr_overrun", {23'd0, ha.overrun}, 24'd0);
        check("clr_ready", {23'd0, ha.snap_ready}, 24'd0);

        // Fresh period with a right-channel clip
        peak_l = 24'h222222;
        sample_a(24'h0, 24'h800001);
        sample_a(24'h0, 24'h0);
        sample_a(24'h0, 24'h0);
        sample_a(24'h0, 24'h0);
        tick();
        check("p3_ready", {23'd0, ha.snap_ready}, 24'd1);
        read_a(3'd0, 24'h222222, "p3_peak_l");
        read_a(3'd4, 24'h000101, "p3_status");

        // snap_clr coincident with wrap while ready: recapture without overrun
        peak_l = 24'h333333;
        sample_a(24'h800000, 24'h0);
        sample_a(24'h800000, 24'h0);
        sample_a(24'h0, 24'h0);
        ha.snap_clr = 1'b1;
        sample_a(24'h0, 24'h0);
        ha.snap_clr = 1'b0;
        check("cw_cap_ready", {23'd0, ha.snap_ready}, 24'd0);
        check("cw_cap_overrun", {23'd0, ha.overrun}, 24'd0);
        tick();
        check("cw_ready", {23'd0, ha.snap_ready}, 24'd1);
        check("cw_overrun", {23'd0, ha.overrun}, 24'd0);
        read_a(3'd0, 24'h333333, "cw_peak_l");
        read_a(3'd4, 24'h020001, "cw_status");

        // Reset mid-operation with a request in flight
        sample_a(24'h0, 24'h0);
        sample_a(24'h0, 24'h0);
        rst_n = 1'b0;
        ha.rd_req = 1'b1;
        ha.rd_sel = 3'd0;
        tick();
        check("mr_ack", {23'd0, ha.rd_ack}, 24'd0);
        check("mr_data", ha.rd_data, 24'd0);
        check("mr_ready", {23'd0, ha.snap_ready}, 24'd0);
        rst_n = 1'b1;
        ha.rd_req = 1'b0;
        tick();
        read_a(3'd0, 24'h000000, "mr_peak_zero");
        read_a(3'd4, 24'h000000, "mr_status_zero");

        // Counter restarted at 0: three samples must not complete a period
        peak_l = 24'h444444;
        for (int i = 0; i < 3; i++) sample_a(24'h0, 24'h0);
        tick();
        tick();
        check("mr_cnt_short", {23'd0, ha.snap_ready}, 24'd0);
        sample_a(24'h0, 24'h0);
        tick();
        check("mr_cnt_full", {23'd0, ha.snap_ready}, 24'd1);

        // Back-to-back reads
        ha.rd_req = 1'b1;
        ha.rd_sel = 3'd0;
        tick();
        check("b2b0_ack", {23'd0, ha.rd_ack}, 24'd1);
        check("b2b0_data", ha.rd_data, 24'h444444);
        ha.rd_sel = 3'd2;
        tick();
        check("b2b1_ack", {23'd0, ha.rd_ack}, 24'd1);
        check("b2b1_data", ha.rd_data, 24'h0A0B0C);
        ha.rd_sel = 3'd7;
        tick();
        check("b2b2_ack", {23'd0, ha.rd_ack}, 24'd1);
        check("b2b2_data", ha.rd_data, 24'h000000);
        ha.rd_req = 1'b0;
        tick();
        check("b2b_end_ack", {23'd0, ha.rd_ack}, 24'd0);
        check("b2b_end_data", ha.rd_data, 24'h000000);

        // Long period: clip saturation and peak pulse mid-period
        in_r = 24'h0;
        for (int i = 0; i < 512; i++) begin
            if (i < 100)       peak_l = 24'h000000;
            else if (i == 100) peak_l = 24'h400000;
            else               peak_l = 24'h001000;
            in_l = (i < 300) ? 24'h7FFFFF : 24'h000000;
            vb   = 1'b1;
            tick();
        end
        vb = 1'b0;
        check("sat_cap_ready", {23'd0, hb.snap_ready}, 24'd0);
        tick();
        check("sat_ready", {23'd0, hb.snap_ready}, 24'd1);
        read_b(3'd4, 24'hFF0001, "sat_status");
        read_b(3'd0, ExpPeakB, "sat_peak_l");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
